// File: rtl/bi_stream_decoder.sv
// Bipolar stochastic bitstream to signed binary converter: counts ones over a
// 2^WIN_LOG2 window, removes the L/2 offset, applies a power-of-two gain and saturates.
module bi_stream_decoder #(
    parameter int WIN_LOG2  = 8,
    parameter int OUT_W     = 8,
    parameter int GAIN_LOG2 = 0,
    parameter int CONT      = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    inStream,
    output logic                    busy,
    output logic                    oValid,
    output logic signed [OUT_W-1:0] oBin
);

    localparam int L  = 1 << WIN_LOG2;
    localparam int DW = WIN_LOG2 + 2;
    localparam int SW = DW + GAIN_LOG2;
    localparam int CW = ((SW > OUT_W) ? SW : OUT_W) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                    state_q;
    logic                      busy_q;
    logic                      valid_q;
    logic signed [OUT_W-1:0]   bin_q;
    logic        [WIN_LOG2:0]  ones_q;
    logic        [WIN_LOG2-1:0] cyc_q;

    logic        [WIN_LOG2:0]  c_d;
    logic signed [DW-1:0]      diff_d;
    logic signed [SW-1:0]      shift_d;
    logic signed [OUT_W-1:0]   bin_d;

    // Clamp the full-width scaled value into the signed OUT_W range.
    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [SW-1:0] s);
        logic signed [CW-1:0] sx;
        logic signed [CW-1:0] hi;
        logic signed [CW-1:0] lo;
        sx = CW'(s);
        hi = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
        lo = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
        if (sx > hi)
            return hi[OUT_W-1:0];
        else if (sx < lo)
            return lo[OUT_W-1:0];
        else
            return sx[OUT_W-1:0];
    endfunction

    // The final count includes the bit sampled on the closing edge of the window.
    always_comb begin
        c_d     = ones_q + (WIN_LOG2+1)'(inStream);
        diff_d  = $signed({1'b0, c_d}) - $signed(DW'(L/2));
        shift_d = SW'(diff_d) <<< GAIN_LOG2;
        bin_d   = sat_out(shift_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            bin_q   <= '0;
            ones_q  <= '0;
            cyc_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        ones_q  <= '0;
                        cyc_q   <= '0;
                    end
                end
                RUN: begin
                    if (&cyc_q) begin
                        bin_q   <= bin_d;
                        valid_q <= 1'b1;
                        ones_q  <= '0;
                        cyc_q   <= '0;
                        // A start on the closing edge chains the next window with no idle gap.
                        if ((CONT != 0) || start) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        ones_q <= ones_q + (WIN_LOG2+1)'(inStream);
                        cyc_q  <= cyc_q + WIN_LOG2'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign oValid = valid_q;
    assign oBin   = bin_q;

endmodule

// File: tb/tb_bi_stream_decoder.sv
// Directed bench for bi_stream_decoder: default, gain-16 and continuous-mode instances.
module tb_bi_stream_decoder;

    localparam int L = 256;

    logic       clk;
    logic       rst_n;
    logic       start_s [3];
    logic       in_s    [3];
    logic       busy_w  [3];
    logic       vld_w   [3];
    logic [7:0] bin_w   [3];

    int n_cmp;
    int n_fail;

    bi_stream_decoder #(.WIN_LOG2(8), .OUT_W(8), .GAIN_LOG2(0), .CONT(0)) u_def (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .inStream(in_s[0]),
        .busy(busy_w[0]), .oValid(vld_w[0]), .oBin(bin_w[0])
    );

    bi_stream_decoder #(.WIN_LOG2(8), .OUT_W(8), .GAIN_LOG2(4), .CONT(0)) u_gain (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .inStream(in_s[1]),
        .busy(busy_w[1]), .oValid(vld_w[1]), .oBin(bin_w[1])
    );

    bi_stream_decoder #(.WIN_LOG2(8), .OUT_W(8), .GAIN_LOG2(0), .CONT(1)) u_cont (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .inStream(in_s[2]),
        .busy(busy_w[2]), .oValid(vld_w[2]), .oBin(bin_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Iteration i sits on the negedge after window edge E_i and drives the bit for E_(i+1).
    task automatic feed(input int sel, input int n1, input bit alt, input bit st_final,
                        input bit st_mid, input bit skip_first);
        for (int i = 0; i < L; i++) begin
            if (!(skip_first && i == 0)) @(negedge clk);
            if (i == 1)     check("vld_one_cycle", vld_w[sel], 1'b0);
            if (i == L/2)   check("busy_mid", busy_w[sel], 1'b1);
            if (i == L-1)   check("vld_early", vld_w[sel], 1'b0);
            start_s[sel] = (st_mid && i == 100) || (st_final && i == L-1);
            in_s[sel]    = alt ? (i % 2 == 0) : (i < n1);
        end
    endtask

    task automatic result(input int sel, input logic [7:0] exp, input logic exp_busy);
        @(negedge clk);
        check("vld_pulse", vld_w[sel], 1'b1);
        check("bin", bin_w[sel], exp);
        check("busy_after", busy_w[sel], exp_busy);
        start_s[sel] = 1'b0;
        in_s[sel]    = 1'b0;
    endtask

    task automatic run_one(input int sel, input int n1, input bit alt, input bit st_mid,
                           input logic [7:0] exp);
        @(negedge clk);
        start_s[sel] = 1'b1;
        feed(sel, n1, alt, 1'b0, st_mid, 1'b0);
        result(sel, exp, 1'b0);
    endtask

    task automatic count_pulses(input int sel, input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (vld_w[sel]) pulses++;
        end
    endtask

    initial begin
        int pulses;
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b0;
            in_s[k]    = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy", busy_w[0], 1'b0);
        check("rst_vld", vld_w[0], 1'b0);
        check("rst_bin", bin_w[0], 8'h00);
        check("rst_busy_cont", busy_w[2], 1'b0);
        rst_n = 1'b1;

        // Default gain: full-scale, zero-scale, midpoint and three-quarter streams.
        run_one(0, 256, 1'b0, 1'b0, 8'h7f);
        run_one(0, 0,   1'b0, 1'b0, 8'h80);
        run_one(0, 0,   1'b1, 1'b0, 8'h00);
        run_one(0, 192, 1'b0, 1'b0, 8'h40);

        // Asynchronous reset in the middle of a window.
        @(negedge clk);
        start_s[0] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start_s[0] = 1'b0;
            in_s[0]    = 1'b1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy_w[0], 1'b0);
        check("midrst_vld", vld_w[0], 1'b0);
        check("midrst_bin", bin_w[0], 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        count_pulses(0, 300, pulses);
        check("midrst_no_pulse", 8'(pulses), 8'h00);
        check("midrst_idle", busy_w[0], 1'b0);
        in_s[0] = 1'b0;

        // Start raised mid-window is ignored: one result, then silence.
        run_one(0, 256, 1'b0, 1'b1, 8'h7f);
        count_pulses(0, 300, pulses);
        check("stmid_single", 8'(pulses), 8'h00);

        // Start held on the closing edge chains a second window without a gap.
        @(negedge clk);
        start_s[0] = 1'b1;
        feed(0, 256, 1'b0, 1'b1, 1'b0, 1'b0);
        result(0, 8'h7f, 1'b1);
        feed(0, 64, 1'b0, 1'b0, 1'b0, 1'b1);
        result(0, 8'(-64), 1'b0);

        // Gain of 16.
        run_one(1, 136, 1'b0, 1'b0, 8'h7f);
        run_one(1, 129, 1'b0, 1'b0, 8'h10);
        run_one(1, 120, 1'b0, 1'b0, 8'h80);
        run_one(1, 127, 1'b0, 1'b0, 8'(-16));

        // Continuous mode: back-to-back windows from a single start.
        @(negedge clk);
        start_s[2] = 1'b1;
        feed(2, 256, 1'b0, 1'b0, 1'b0, 1'b0);
        result(2, 8'h7f, 1'b1);
        feed(2, 256, 1'b0, 1'b0, 1'b0, 1'b1);
        result(2, 8'h7f, 1'b1);
        feed(2, 128, 1'b0, 1'b0, 1'b0, 1'b1);
        result(2, 8'h00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bi_stream_decoder.md
Name: bi_stream_decoder

Overview:
- Converts a bipolar stochastic bitstream back into a signed binary word. It is the receive-side counterpart to the stochastic MAC units, which emit one bit per cycle.
- Counts 1s over a fixed window of 2^WIN_LOG2 cycles, removes the bipolar offset, applies an optional power-of-two gain and saturates to OUT_W bits.
- Sits at the output of a MAC or adder tree so the result can be checked or stored in binary.

Parameters:
- WIN_LOG2, 8: window length is 2^WIN_LOG2 cycles; matches the 8-bit Sobol sequence period.
- OUT_W, 8: width of the signed output word.
- GAIN_LOG2, 0: left shift applied after offset removal. Set to 4 to undo the 1/16 scaling of a 16-input mux adder.
- CONT, 0: 1 = back-to-back windows with no idle cycle; 0 = one window per start.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous reset, active low.
- start, input, 1: request a new conversion window.
- inStream, input, 1: bipolar stochastic bit, sampled every RUN cycle.
- busy, output, 1: high while a window is in progress.
- oValid, output, 1: one-cycle pulse when oBin is updated.
- oBin, output, OUT_W: signed result; holds its value until the next update.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; onesCnt=0; cycCnt=0.
  - busy=0, oValid=0, oBin=0.
  - Reset mid-window discards the partial count; no oValid is produced.
- States: IDLE and RUN.
- IDLE:
  - start=1 at edge E0 -> RUN; onesCnt=0, cycCnt=0.
  - busy goes high after E0.
  - inStream is ignored while in IDLE.
- RUN:
  - At each edge E1..EL (L=2^WIN_LOG2): onesCnt += inStream; cycCnt++.
  - onesCnt is WIN_LOG2+1 bits wide, range 0..L.
  - start is ignored while RUN, except on the final cycle (see below).
- Final edge EL (cycCnt==L-1):
  - c = onesCnt + inStream, including the bit sampled at EL.
  - d = c - L/2, signed, range -L/2..+L/2.
  - s = d << GAIN_LOG2, computed at full width.
  - oBin = s saturated to the range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - oValid=1 for exactly the cycle after EL.
- Latency: start accepted at E0 -> oValid high after E_L (L+1 edges after acceptance).
- After the final edge:
  - If CONT=1 or start=1 at EL: stay in RUN, counters cleared, next window samples from E(L+1). oValid pulses are spaced exactly L cycles apart.
  - Otherwise: go to IDLE, busy=0.
- Bipolar mapping (defaults): value = 2p-1 and oBin = value*128 = c-128. A count of c=256 saturates to +127; c=0 gives -128.
- cycCnt wraps from L-1 to 0 only in the final-edge handling above; there is no other wrap.

Test Plan:
- start pulse, inStream=1 for 256 cycles -> oValid exactly 257 edges after the start edge, oBin=+127 (saturated), busy falls the same cycle.
- start, inStream=0 for 256 cycles -> oBin=-128 (0x80).
- start, alternating 1/0 pattern (128 ones) -> oBin=0. Then 192 ones and 64 zeros -> oBin=+64.
- GAIN_LOG2=4:
  - 136 ones -> d=8, s=128 -> oBin=+127 (saturated).
  - 129 ones -> oBin=+16.
  - 120 ones -> oBin=-128.
- CONT=1, continuous all-ones stream -> oValid every 256 cycles with oBin=127, busy stays high, no gap cycles.
- Reset checks:
  - rst_n low at cycle 100 of a window -> busy=0, oValid=0, oBin=0 immediately; no pulse follows.
  - start during RUN is ignored, confirmed by a single oValid.
  - start held at the final edge -> next window starts with no gap.
